// File: rtl/lae_control_gen_if.sv
// Control/handshake bundle for lae_control_gen; the controller sits on the slave side.
// The hold line exists only when LAE_CONTROL_STALL_EN is defined.
interface lae_control_gen_if #(
    parameter int RCON_W = 5
) ();
    logic              start;
    logic              ain;
    logic              min;
    logic              last;
    logic              in_valid;
`ifdef LAE_CONTROL_STALL_EN
    logic              hold;
`endif
    logic              init;
    logic              getdata;
    logic              getdata0;
    logic              outc;
    logic              final_o;
    logic [RCON_W-1:0] rcon;
    logic              busy;
    logic              done;

    modport master (
        output start, ain, min, last, in_valid,
`ifdef LAE_CONTROL_STALL_EN
        output hold,
`endif
        input  init, getdata, getdata0, outc, final_o, rcon, busy, done
    );

    modport slave (
        input  start, ain, min, last, in_valid,
`ifdef LAE_CONTROL_STALL_EN
        input  hold,
`endif
        output init, getdata, getdata0, outc, final_o, rcon, busy, done
    );
endinterface

// File: rtl/lae_control_gen.sv
// Round/phase controller for the TI authenticated-encryption datapath: init, absorb, final, done.
// Optional pipeline stall input enabled by defining LAE_CONTROL_STALL_EN.
module lae_control_gen #(
    parameter int ROUNDS = 16,
    parameter int STAGES = 1,
    parameter int RCON_W = 5
) (
    input logic             ck,
    input logic             rst,
    lae_control_gen_if.slave bus
);
    localparam int CNT_W = $clog2(ROUNDS);
    localparam int STG_W = (STAGES > 1) ? $clog2(STAGES) : 1;
    localparam logic [CNT_W-1:0] RND_LAST = CNT_W'(ROUNDS - 1);
    localparam logic [STG_W-1:0] STG_LAST = STG_W'(STAGES - 1);

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        WAIT,
        ABSORB,
        FINAL,
        DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] rnd;
    logic [STG_W-1:0] stg;
    logic             busy_w;
    logic             init_w;

    assign busy_w = (state == INIT) || (state == ABSORB) || (state == FINAL);

    always_ff @(posedge ck) begin
        if (rst) begin
            state <= IDLE;
            rnd   <= '0;
            stg   <= '0;
        end else if (bus.start) begin
            state <= INIT;
            rnd   <= '0;
            stg   <= '0;
`ifdef LAE_CONTROL_STALL_EN
        end else if (!(bus.hold && busy_w)) begin
`else
        end else begin
`endif
            case (state)
                INIT, FINAL: begin
                    if (stg == STG_LAST) begin
                        stg <= '0;
                        if (rnd == RND_LAST) begin
                            rnd   <= '0;
                            state <= (state == INIT) ? WAIT : DONE;
                        end else begin
                            rnd <= rnd + CNT_W'(1);
                        end
                    end else begin
                        stg <= stg + STG_W'(1);
                    end
                end
                WAIT: begin
                    if (bus.in_valid) begin
                        state <= bus.last ? FINAL : ABSORB;
                    end
                end
                // A data block costs a single round with the round counter parked at zero.
                ABSORB: begin
                    if (stg == STG_LAST) begin
                        stg   <= '0;
                        state <= WAIT;
                    end else begin
                        stg <= stg + STG_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign init_w       = (state == INIT) && (rnd == '0) && (stg == '0);
    assign bus.init     = init_w;
    assign bus.getdata  = (state == WAIT);
    assign bus.getdata0 = init_w && bus.ain;
    assign bus.outc     = bus.min;
    assign bus.final_o  = (state == FINAL) && (rnd == RND_LAST) && (stg == STG_LAST);
    assign bus.rcon     = RCON_W'(rnd);
    assign bus.busy     = busy_w;
    assign bus.done     = (state == DONE);
endmodule

// File: tb/tb_lae_control_gen.sv
// Scoreboard bench for lae_control_gen: dut_a uses defaults, dut_b uses ROUNDS=8, STAGES=3.
// Hold scenarios run only when LAE_CONTROL_STALL_EN is defined.
module tb_lae_control_gen;
    typedef struct packed {
        logic rst;
        logic start;
        logic ain;
        logic min;
        logic last;
        logic in_valid;
        logic hold;
    } stim_t;

    typedef struct packed {
        logic       init;
        logic       getdata;
        logic       getdata0;
        logic       outc;
        logic       final_o;
        logic       busy;
        logic       done;
        logic [4:0] rcon;
    } exp_t;

    logic ck = 1'b0;
    logic rst_a;
    logic rst_b;
    int   checks = 0;
    int   errors = 0;
    exp_t q_a[$];
    exp_t q_b[$];

    always #5 ck = ~ck;

    lae_control_gen_if #(.RCON_W(5)) bus_a ();
    lae_control_gen_if #(.RCON_W(5)) bus_b ();

    lae_control_gen #(.ROUNDS(16), .STAGES(1), .RCON_W(5)) dut_a (
        .ck (ck),
        .rst(rst_a),
        .bus(bus_a)
    );

    lae_control_gen #(.ROUNDS(8), .STAGES(3), .RCON_W(5)) dut_b (
        .ck (ck),
        .rst(rst_b),
        .bus(bus_b)
    );

    function automatic stim_t st(input bit rst, input bit start, input bit ain, input bit min,
                                 input bit last, input bit in_valid, input bit hold);
        stim_t s;
        s = '{rst, start, ain, min, last, in_valid, hold};
        return s;
    endfunction

    // Argument order: init, getdata, getdata0, outc, final_o, busy, done, rcon.
    function automatic exp_t ex(input bit init, input bit getdata, input bit getdata0, input bit outc,
                                input bit final_o, input bit busy, input bit done, input int rcon);
        exp_t e;
        e = '{init, getdata, getdata0, outc, final_o, busy, done, 5'(rcon)};
        return e;
    endfunction

    task automatic check_output(input string name, input exp_t act, input exp_t req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s {init,getdata,getdata0,outc,final,busy,done,rcon} got %b required %b at %0t",
                     name, act, req, $time);
        end
    endtask

    // Drive one cycle of inputs and queue the outputs expected during that cycle.
    task automatic apply_stimulus(input bit sel, input stim_t s, input exp_t e);
        if (!sel) begin
            rst_a          = s.rst;
            bus_a.start    = s.start;
            bus_a.ain      = s.ain;
            bus_a.min      = s.min;
            bus_a.last     = s.last;
            bus_a.in_valid = s.in_valid;
`ifdef LAE_CONTROL_STALL_EN
            bus_a.hold     = s.hold;
`endif
            q_a.push_back(e);
        end else begin
            rst_b          = s.rst;
            bus_b.start    = s.start;
            bus_b.ain      = s.ain;
            bus_b.min      = s.min;
            bus_b.last     = s.last;
            bus_b.in_valid = s.in_valid;
`ifdef LAE_CONTROL_STALL_EN
            bus_b.hold     = s.hold;
`endif
            q_b.push_back(e);
        end
        @(posedge ck);
        #1;
    endtask

    always @(negedge ck) begin
        if (q_a.size() > 0) begin
            check_output("dut_a", {bus_a.init, bus_a.getdata, bus_a.getdata0, bus_a.outc,
                                   bus_a.final_o, bus_a.busy, bus_a.done, bus_a.rcon}, q_a.pop_front());
        end
    end

    always @(negedge ck) begin
        if (q_b.size() > 0) begin
            check_output("dut_b", {bus_b.init, bus_b.getdata, bus_b.getdata0, bus_b.outc,
                                   bus_b.final_o, bus_b.busy, bus_b.done, bus_b.rcon}, q_b.pop_front());
        end
    end

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        {bus_a.start, bus_a.ain, bus_a.min, bus_a.last, bus_a.in_valid} = '0;
        {bus_b.start, bus_b.ain, bus_b.min, bus_b.last, bus_b.in_valid} = '0;
`ifdef LAE_CONTROL_STALL_EN
        bus_a.hold = 1'b0;
        bus_b.hold = 1'b0;
`endif
        @(posedge ck);
        #1;

        // Reset with outc following min, then start with ain set.
        apply_stimulus(0, st(1, 0, 0, 1, 0, 0, 0), ex(0, 0, 0, 1, 0, 0, 0, 0));
        apply_stimulus(0, st(0, 1, 1, 0, 0, 0, 0), ex(0, 0, 0, 0, 0, 0, 0, 0));
        apply_stimulus(0, st(0, 0, 1, 0, 0, 0, 0), ex(1, 0, 1, 0, 0, 1, 0, 0));
        for (int i = 1; i < 16; i++)
            apply_stimulus(0, st(0, 0, 1, 0, 0, 0, 0), ex(0, 0, 0, 0, 0, 1, 0, i));
        apply_stimulus(0, st(0, 0, 0, 0, 0, 0, 0), ex(0, 1, 0, 0, 0, 0, 0, 0));

        // Three absorb blocks, then the last block into finalisation.
        for (int k = 0; k < 3; k++) begin
            apply_stimulus(0, st(0, 0, 0, k[0], 0, 1, 0), ex(0, 1, 0, k[0], 0, 0, 0, 0));
            apply_stimulus(0, st(0, 0, 0, 0, 1, 1, 0), ex(0, 0, 0, 0, 0, 1, 0, 0));
        end
        apply_stimulus(0, st(0, 0, 0, 1, 1, 1, 0), ex(0, 1, 0, 1, 0, 0, 0, 0));
        for (int i = 0; i < 16; i++)
            apply_stimulus(0, st(0, 0, 0, 0, 1, 1, 0), ex(0, 0, 0, 0, (i == 15), 1, 0, i));
        apply_stimulus(0, st(0, 0, 0, 0, 0, 0, 0), ex(0, 0, 0, 0, 0, 0, 1, 0));
        apply_stimulus(0, st(0, 0, 0, 0, 0, 1, 0), ex(0, 0, 0, 0, 0, 0, 1, 0));

        // Restart from DONE, then start again mid-FINAL at rcon 9.
        apply_stimulus(0, st(0, 1, 0, 0, 0, 0, 0), ex(0, 0, 0, 0, 0, 0, 1, 0));
        apply_stimulus(0, st(0, 0, 0, 0, 0, 0, 0), ex(1, 0, 0, 0, 0, 1, 0, 0));
        for (int i = 1; i < 16; i++)
            apply_stimulus(0, st(0, 0, 0, 0, 0, 0, 0), ex(0, 0, 0, 0, 0, 1, 0, i));
        apply_stimulus(0, st(0, 0, 0, 0, 1, 1, 0), ex(0, 1, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 9; i++)
            apply_stimulus(0, st(0, 0, 0, 0, 0, 0, 0), ex(0, 0, 0, 0, 0, 1, 0, i));
        apply_stimulus(0, st(0, 1, 0, 0, 0, 0, 0), ex(0, 0, 0, 0, 0, 1, 0, 9));
        apply_stimulus(0, st(0, 0, 1, 0, 0, 0, 0), ex(1, 0, 1, 0, 0, 1, 0, 0));
        for (int i = 1; i < 16; i++)
            apply_stimulus(0, st(0, 0, 0, 0, 0, 0, 0), ex(0, 0, 0, 0, 0, 1, 0, i));

        // Reset together with start while absorbing.
        apply_stimulus(0, st(0, 0, 0, 0, 0, 1, 0), ex(0, 1, 0, 0, 0, 0, 0, 0));
        apply_stimulus(0, st(1, 1, 0, 0, 0, 0, 0), ex(0, 0, 0, 0, 0, 1, 0, 0));
        apply_stimulus(0, st(0, 0, 0, 0, 0, 0, 0), ex(0, 0, 0, 0, 0, 0, 0, 0));
        apply_stimulus(0, st(0, 0, 0, 0, 0, 1, 0), ex(0, 0, 0, 0, 0, 0, 0, 0));

`ifdef LAE_CONTROL_STALL_EN
        // Hold four cycles at INIT rcon 5; hold during WAIT must not block the handshake.
        apply_stimulus(0, st(0, 1, 0, 0, 0, 0, 1), ex(0, 0, 0, 0, 0, 0, 0, 0));
        apply_stimulus(0, st(0, 0, 0, 0, 0, 0, 0), ex(1, 0, 0, 0, 0, 1, 0, 0));
        for (int i = 1; i < 5; i++)
            apply_stimulus(0, st(0, 0, 0, 0, 0, 0, 0), ex(0, 0, 0, 0, 0, 1, 0, i));
        for (int i = 0; i < 4; i++)
            apply_stimulus(0, st(0, 0, 0, 0, 0, 0, 1), ex(0, 0, 0, 0, 0, 1, 0, 5));
        for (int i = 5; i < 16; i++)
            apply_stimulus(0, st(0, 0, 0, 0, 0, 0, 0), ex(0, 0, 0, 0, 0, 1, 0, i));
        apply_stimulus(0, st(0, 0, 0, 0, 0, 1, 1), ex(0, 1, 0, 0, 0, 0, 0, 0));
        apply_stimulus(0, st(0, 0, 0, 0, 0, 0, 0), ex(0, 0, 0, 0, 0, 1, 0, 0));
        apply_stimulus(0, st(0, 0, 0, 0, 0, 0, 1), ex(0, 1, 0, 0, 0, 0, 0, 0));
`endif

        // Three-stage rounds on dut_b: each rcon held three cycles.
        apply_stimulus(1, st(1, 0, 0, 0, 0, 0, 0), ex(0, 0, 0, 0, 0, 0, 0, 0));
        apply_stimulus(1, st(0, 1, 0, 0, 0, 0, 0), ex(0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 24; i++)
            apply_stimulus(1, st(0, 0, 0, 0, 0, 0, 0), ex((i == 0), 0, 0, 0, 0, 1, 0, i / 3));
        apply_stimulus(1, st(0, 0, 0, 0, 0, 1, 0), ex(0, 1, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++)
            apply_stimulus(1, st(0, 0, 0, 0, 0, 0, 0), ex(0, 0, 0, 0, 0, 1, 0, 0));
        apply_stimulus(1, st(0, 0, 0, 0, 1, 1, 0), ex(0, 1, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 24; i++)
            apply_stimulus(1, st(0, 0, 0, 0, 0, 0, 0), ex(0, 0, 0, 0, (i == 23), 1, 0, i / 3));
        apply_stimulus(1, st(0, 0, 0, 0, 0, 0, 0), ex(0, 0, 0, 0, 0, 0, 1, 0));

        @(posedge ck);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lae_control_gen.md
Name: lae_control_gen

Overview:
- Parametrised round/phase controller for the Fides-family threshold-implementation (TI) authenticated-encryption datapath. Successor to the fixed 16-round, 1-cycle-per-round control block.
- Sequences four phases: initialisation rounds, per-block absorb rounds, finalisation rounds, done.
- Supports multi-cycle rounds (TI pipeline stages) and a handshake on data availability.
- Drives the round constant plus the init/getdata/final strobes consumed by the state and share-update logic.

Parameters:
- ROUNDS, 16: rounds in the init and final phases; ROUNDS >= 2.
- STAGES, 1: clock cycles per round (TI pipeline depth); STAGES >= 1.
- RCON_W, 5: rcon output width; must be >= CNT_W.
- CNT_W, $clog2(ROUNDS): round-counter width (localparam, derived).

Ports:
- ck  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  begin new operation; synchronous restart from any state.
- ain  input  1  associated-data-present flag, sampled at init start.
- min  input  1  message-phase flag from the input side.
- last  input  1  current data block is the final block.
- in_valid  input  1  data block available on the datapath input.
- init  output  1  first cycle of init phase.
- getdata  output  1  controller is waiting for a data block.
- getdata0  output  1  init && ain.
- outc  output  1  equals min (combinational pass-through).
- final_o  output  1  one-cycle pulse on the last cycle of the last final round.
- rcon  output  RCON_W  zero-extended round counter.
- busy  output  1  state is INIT, ABSORB or FINAL.
- done  output  1  state is DONE.

Behaviour:
- Counters:
  - stg: 0..STAGES-1.
  - rnd: 0..ROUNDS-1.
  - A round boundary occurs when stg == STAGES-1 while busy. At a boundary stg -> 0 and rnd increments; otherwise stg increments.
  - rnd wraps ROUNDS-1 -> 0 at the end of a phase.
- FSM states: IDLE, INIT, WAIT, ABSORB, FINAL, DONE.
- Reset: state = IDLE, rnd = 0, stg = 0. All outputs 0 except outc, which follows min.
- Priority: rst > start > normal transitions. start in any state (including mid-round) sets rnd = 0, stg = 0, state = INIT next cycle.
- INIT:
  - Runs ROUNDS rounds.
  - init = 1 only when rnd == 0 and stg == 0; getdata0 = init && ain.
  - After the boundary at rnd == ROUNDS-1: go to WAIT, rnd = 0.
- WAIT:
  - getdata = 1; counters hold.
  - in_valid && !last: go to ABSORB.
  - in_valid && last: go to FINAL.
  - in_valid low: stay; no timeout.
- ABSORB: exactly one round (STAGES cycles) with rcon = 0, then back to WAIT; rnd stays 0.
- FINAL:
  - Runs ROUNDS rounds.
  - final_o = 1 when rnd == ROUNDS-1 and stg == STAGES-1.
  - Next state DONE.
- DONE: done = 1; holds until start or rst.
- rcon = {(RCON_W-CNT_W) zeros, rnd}, combinational from the registered counter.
- busy = state in {INIT, ABSORB, FINAL}.
- last and in_valid are ignored outside WAIT.
- Latency:
  - start to init = 1 cycle.
  - in_valid to first ABSORB/FINAL cycle = 1 cycle.
  - Total init phase = ROUNDS*STAGES cycles.

Optional Feature:
- Macro: LAE_CONTROL_STALL_EN.
- When defined:
  - Adds input port `hold` (1 bit).
  - While hold = 1 in INIT, ABSORB or FINAL: stg, rnd and state freeze, and strobes keep their current values (final_o stays high if frozen on its cycle).
  - hold is ignored in IDLE, WAIT and DONE.
  - start and rst override hold.
- When undefined: no hold port; counters advance unconditionally.

Test Plan:
- Defaults, rst for 2 cycles, then start = 1 for 1 cycle with ain = 1 -> next cycle init = 1, getdata0 = 1, rcon = 0. rcon counts 0..15 over 16 cycles, then getdata = 1, busy = 0.
- Defaults, in WAIT: in_valid = 1, last = 0 for 3 blocks -> each block gives 1 busy cycle with rcon = 0, then getdata = 1. Then in_valid = 1, last = 1 -> rcon 0..15, final_o high only at rcon = 15, then done = 1.
- STAGES = 3, ROUNDS = 8, RCON_W = 5 -> each rcon value held 3 cycles. Init lasts 24 cycles; final_o high for exactly 1 cycle at rcon = 7, stg = 2.
- start asserted mid-FINAL at rcon = 9 -> next cycle state INIT, rcon = 0, init = 1; final_o never pulses.
- rst asserted mid-ABSORB and simultaneously with start -> next cycle IDLE, all outputs 0, busy = 0, done = 0.
- LAE_CONTROL_STALL_EN defined: hold = 1 for 4 cycles at INIT rcon = 5 -> rcon stays 5 for 5 cycles total. Init completes after 20 cycles; hold during WAIT has no effect.
